// File: rtl/lut_cfg_pkg.sv
// Shared types and helpers for the LUT3 configuration loader.
// Table width, FSM encoding and the X-aware 2:1 merge used by lut3_eval.
package lut_cfg_pkg;

    localparam int LUT3_BITS = 8;
    localparam int CNT_W     = 3;

    localparam logic [CNT_W-1:0] CNT_LAST = 3'd7;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } state_t;

    // Unknown select yields the common value of both legs, else X.
    function automatic logic lut_mux2(
        input logic s,
        input logic hi,
        input logic lo
    );
        if (s)
            return hi;
        else if (!s)
            return lo;
        else
            return (hi == lo) ? hi : 1'bx;
    endfunction

endpackage

// File: rtl/lut3_eval.sv
// Combinational 8:1 table select addressed by {I2,I1,I0}.
// Unknown select bits merge the addressed entries instead of forcing X.
module lut3_eval
    import lut_cfg_pkg::*;
(
    input  logic [LUT3_BITS-1:0] tbl,
    input  logic [2:0]           sel,
    output logic                 o
);

    logic [3:0] l0;
    logic [1:0] l1;

    // Three-level mux tree so each select bit merges independently.
    always_comb begin
        l0 = '0;
        l1 = '0;
        for (int i = 0; i < 4; i++)
            l0[i] = lut_mux2(sel[0], tbl[2*i+1], tbl[2*i]);
        for (int j = 0; j < 2; j++)
            l1[j] = lut_mux2(sel[1], l0[2*j+1], l0[2*j]);
    end

    assign o = lut_mux2(sel[2], l1[1], l1[0]);

endmodule

// File: rtl/lut3_cfg_loader.sv
// Runtime-reconfigurable LUT3: serial shadow load, atomic commit.
// O/LO always evaluate the active table; the shadow is never visible.
module lut3_cfg_loader
    import lut_cfg_pkg::*;
#(
    parameter logic [LUT3_BITS-1:0] INIT = 8'h00
) (
    input  logic                 CLK,
    input  logic                 CLR,
    input  logic                 CE,
    input  logic                 WR_VALID,
    input  logic [LUT3_BITS-1:0] WR_DATA,
    output logic                 WR_READY,
    input  logic                 I0,
    input  logic                 I1,
    input  logic                 I2,
    output logic                 O,
    output logic                 LO,
    output logic                 CDO,
    output logic                 BUSY,
    output logic                 DONE
);

    state_t               state;
    logic [LUT3_BITS-1:0] active;
    logic [LUT3_BITS-1:0] shadow;
    logic [LUT3_BITS-1:0] load;
    logic [CNT_W-1:0]     count;

    // Handshake, serial shift and commit; CE freezes everything.
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            state    <= IDLE;
            active   <= INIT;
            shadow   <= INIT;
            load     <= '0;
            count    <= '0;
            WR_READY <= 1'b1;
            BUSY     <= 1'b0;
            DONE     <= 1'b0;
        end else if (CE) begin
            DONE <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (WR_VALID && WR_READY) begin
                        load     <= WR_DATA;
                        count    <= '0;
                        state    <= SHIFT;
                        WR_READY <= 1'b0;
                        BUSY     <= 1'b1;
                    end
                end
                SHIFT: begin
                    shadow <= {shadow[LUT3_BITS-2:0],
                               load[CNT_LAST - count]};
                    count  <= count + 3'd1;
                    if (count == CNT_LAST)
                        state <= COMMIT;
                end
                COMMIT: begin
                    active   <= shadow;
                    state    <= IDLE;
                    WR_READY <= 1'b1;
                    BUSY     <= 1'b0;
                    DONE     <= 1'b1;
                end
                default: begin
                    state    <= IDLE;
                    WR_READY <= 1'b1;
                    BUSY     <= 1'b0;
                end
            endcase
        end
    end

    assign CDO = shadow[LUT3_BITS-1];

    lut3_eval u_eval_o (
        .tbl (active),
        .sel ({I2, I1, I0}),
        .o   (O)
    );

    lut3_eval u_eval_lo (
        .tbl (active),
        .sel ({I2, I1, I0}),
        .o   (LO)
    );

endmodule
